alu_arbiter: RTL and testbench

Shares the single combinational ALU between two requesters, the execute stage (port 0) and the address-generation unit (port 1), using round-robin arbitration over valid/ready handshakes. It captures the winning requester's operands, drives the ALU for one cycle, registers the result and flags, and returns them to the granted port only. One operation is in flight at a time. The block sits between the decode/issue logic and the ALU instance, and the ALU is instantiated inside it.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu.sv | 65 ++++++
 rtl/rr_arb2.sv | 15 +
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU, the round-robin arbiter and the
// arbiter top level.
//   - FS_* : function-select encodings understood by the ALU
//   - fs_legal() : true for the encodings the ALU implements
//   - flags_t : packed {z, v, n, c} condition flags
//   - state_t : arbiter FSM state encoding
package alu_pkg;

  localparam logic [4:0] FS_MOV = 5'b00000;
  localparam logic [4:0] FS_ADD = 5'b00010;
  localparam logic [4:0] FS_SUB = 5'b00101;
  localparam logic [4:0] FS_AND = 5'b01000;
  localparam logic [4:0] FS_OR  = 5'b01010;
  localparam logic [4:0] FS_XOR = 5'b01100;
  localparam logic [4:0] FS_NOT = 5'b01110;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10001;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
    logic c;
  } flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic fs_legal(input logic [4:0] fs);
    case (fs)
      FS_MOV, FS_ADD, FS_SUB, FS_AND, FS_OR,
      FS_XOR, FS_NOT, FS_LSL, FS_LSR: fs_legal = 1'b1;
      default:                        fs_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// alu: purely combinational ALU.
//   a_i, b_i : operands
//   fs_i     : function select (alu_pkg::FS_*)
//   sh_i     : shift amount for LSL/LSR
//   f_o      : result (wraps at W bits)
//   flags_o  : {z, v, n, c}; SUB carry is the borrow, LSL carry is A[W-1],
//              LSR carry is A[0]. Unknown encodings give F = 0.
module alu
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [4:0]   fs_i,
  input  logic [4:0]   sh_i,
  output logic [W-1:0] f_o,
  output flags_t       flags_o
);

  logic [W:0] wide;
  logic       cy;
  logic       ov;

  always_comb begin
    f_o  = '0;
    wide = '0;
    cy   = 1'b0;
    ov   = 1'b0;
    case (fs_i)
      FS_MOV: f_o = a_i;
      FS_ADD: begin
        wide = {1'b0, a_i} + {1'b0, b_i};
        f_o  = wide[W-1:0];
        cy   = wide[W];
        ov   = (a_i[W-1] == b_i[W-1]) && (f_o[W-1] != a_i[W-1]);
      end
      FS_SUB: begin
        // Bit W of the widened difference is set exactly when a borrow occurs.
        wide = {1'b0, a_i} - {1'b0, b_i};
        f_o  = wide[W-1:0];
        cy   = wide[W];
        ov   = (a_i[W-1] != b_i[W-1]) && (f_o[W-1] != a_i[W-1]);
      end
      FS_AND: f_o = a_i & b_i;
      FS_OR:  f_o = a_i | b_i;
      FS_XOR: f_o = a_i ^ b_i;
      FS_NOT: f_o = ~a_i;
      FS_LSL: begin
        f_o = a_i << sh_i;
        cy  = a_i[W-1];
      end
      FS_LSR: begin
        f_o = a_i >> sh_i;
        cy  = a_i[0];
      end
      default: f_o = '0;
    endcase
    flags_o.z = (f_o == '0);
    flags_o.v = ov;
    flags_o.n = f_o[W-1];
    flags_o.c = cy;
  end

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant, combinational.
//   valid_i : request lines
//   last_i  : index of the port served most recently
//   grant_o : one-hot grant (or zero when nothing is requested)
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // On a tie the port that was not served last wins.
  assign grant_o[0] = valid_i[0] & (~valid_i[1] | last_i);
  assign grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_i);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between the execute stage (port 0) and the
// address-generation unit (port 1) with round-robin arbitration. One
// operation is in flight at a time: IDLE (grant/capture) -> EXEC (ALU
// evaluates captured operands, result registered) -> RESP (held until the
// granted port consumes it).
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid/ready[i] : request handshake per port
//   req_a/b/fs/sh[i]   : operands, function select, shift amount per port
//   resp_valid/ready[i]: response handshake per port
//   resp_f, resp_z/v/n/c, resp_err : registered result, flags, illegal-FS flag
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0][W-1:0]   req_a,
  input  logic [1:0][W-1:0]   req_b,
  input  logic [1:0][4:0]     req_fs,
  input  logic [1:0][4:0]     req_sh,
  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [W-1:0]        resp_f,
  output logic                resp_z,
  output logic                resp_v,
  output logic                resp_n,
  output logic                resp_c,
  output logic                resp_err
);

  state_t         state_q, state_d;
  logic           last_q;
  logic           gnt_q;
  logic [W-1:0]   a_q, b_q;
  logic [4:0]     fs_q, sh_q;
  logic [W-1:0]   f_q;
  flags_t         flags_q;
  logic           err_q;

  logic [1:0]     grant;
  logic           accept;
  logic           gidx;
  logic [W-1:0]   alu_f;
  flags_t         alu_flags;

  rr_arb2 u_arb (
    .valid_i (req_valid),
    .last_i  (last_q),
    .grant_o (grant)
  );

  alu #(.W(W)) u_alu (
    .a_i     (a_q),
    .b_i     (b_q),
    .fs_i    (fs_q),
    .sh_i    (sh_q),
    .f_o     (alu_f),
    .flags_o (alu_flags)
  );

  assign gidx = grant[1];

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    case (state_q)
      ST_IDLE: begin
        // Gated by rst_n so ready reads 0 while reset is held.
        req_ready = rst_n ? grant : 2'b00;
        accept    = |grant;
        if (accept) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        resp_valid = gnt_q ? 2'b10 : 2'b01;
        if (resp_ready[gnt_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q <= gidx;
        gnt_q  <= gidx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      fs_q    <= '0;
      sh_q    <= '0;
      f_q     <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= req_a[gidx];
        b_q  <= req_b[gidx];
        fs_q <= req_fs[gidx];
        sh_q <= req_sh[gidx];
      end
      if (state_q == ST_EXEC) begin
        if (fs_legal(fs_q)) begin
          f_q     <= alu_f;
          flags_q <= alu_flags;
          err_q   <= 1'b0;
        end else begin
          f_q     <= '0;
          flags_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign resp_f   = f_q;
  assign resp_z   = flags_q.z;
  assign resp_v   = flags_q.v;
  assign resp_n   = flags_q.n;
  assign resp_c   = flags_q.c;
  assign resp_err = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][31:0]  req_a, req_b;
  logic [1:0][4:0]   req_fs, req_sh;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [31:0]       resp_f;
  logic              resp_z, resp_v, resp_n, resp_c, resp_err;

  always #5 clk = ~clk;

  alu_arbiter #(.W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_fs     (req_fs),
    .req_sh     (req_sh),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_f     (resp_f),
    .resp_z     (resp_z),
    .resp_v     (resp_v),
    .resp_n     (resp_n),
    .resp_c     (resp_c),
    .resp_err   (resp_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Legal function-select codes: MOV ADD SUB AND OR XOR NOT LSL LSR.
  logic [4:0] legal_fs [9] = '{5'h00, 5'h02, 5'h05, 5'h08, 5'h0A, 5'h0C, 5'h0E, 5'h10, 5'h11};

  // Reference: results from plain integer arithmetic. zvnc = {z, v, n, c}.
  function automatic void model(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] f,
                                output logic [3:0] zvnc, output logic err);
    int     ai, bi, t;
    longint sa, sb, r;
    bit     legal, v, c;
    legal = 0; v = 0; c = 0;
    ai = a; bi = b; sa = ai; sb = bi;
    foreach (legal_fs[k]) if (legal_fs[k] == fs) legal = 1;
    f = 32'd0; zvnc = 4'd0; err = 1'b0;
    if (!legal) begin
      err = 1'b1;
      return;
    end
    case (fs)
      5'h00: f = a;
      5'h02: begin
        r = sa + sb; t = int'(r); v = (longint'(t) != r);
        f = a + b;
        c = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
      end
      5'h05: begin
        r = sa - sb; t = int'(r); v = (longint'(t) != r);
        f = a - b;
        c = (a < b);
      end
      5'h08: f = a & b;
      5'h0A: f = a | b;
      5'h0C: f = a ^ b;
      5'h0E: f = ~a;
      5'h10: begin f = a << sh; c = a[31]; end
      default: begin f = a >> sh; c = a[0]; end
    endcase
    zvnc = {(f == 32'd0), v, f[31], c};
  endfunction

  logic [4:0]  op_fs [2];
  logic [4:0]  op_sh [2];
  logic [31:0] op_a  [2];
  logic [31:0] op_b  [2];
  bit          pend  [2];
  int          last_served;

  logic [31:0] obs_f;
  logic [3:0]  obs_flags;
  logic        obs_err;
  logic [1:0]  obs_grant;

  task automatic drive_reqs();
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = pend[p];
      req_a[p]     = op_a[p];
      req_b[p]     = op_b[p];
      req_fs[p]    = op_fs[p];
      req_sh[p]    = op_sh[p];
    end
  endtask

  task automatic set_op(input int p, input logic [4:0] fs, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    op_fs[p] = fs; op_a[p] = a; op_b[p] = b; op_sh[p] = sh; pend[p] = 1;
  endtask

  // Entered and left at posedge+1: one full arbitration, execution and response.
  task automatic serve(input int hold);
    int          g;
    logic [1:0]  oh;
    logic [31:0] ef;
    logic [3:0]  efl;
    logic        eerr;
    drive_reqs();
    #1;
    if (!pend[0] && !pend[1]) begin
      check("idle_ready", req_ready, 2'b00);
      check("idle_rvalid", resp_valid, 2'b00);
      @(posedge clk); #1;
      return;
    end
    if (pend[0] && pend[1]) g = (last_served == 1) ? 0 : 1;
    else                    g = pend[0] ? 0 : 1;
    oh = 2'b01 << g;
    obs_grant = req_ready;
    check("grant", req_ready, oh);
    model(op_fs[g], op_a[g], op_b[g], op_sh[g], ef, efl, eerr);
    @(posedge clk); #1;
    pend[g] = 0;
    last_served = g;
    drive_reqs();
    #1;
    check("exec_ready", req_ready, 2'b00);
    check("exec_rvalid", resp_valid, 2'b00);
    @(posedge clk); #1;
    obs_f = resp_f; obs_flags = {resp_z, resp_v, resp_n, resp_c}; obs_err = resp_err;
    check("resp_valid", resp_valid, oh);
    check("resp_f", resp_f, ef);
    check("resp_flags", {resp_z, resp_v, resp_n, resp_c}, efl);
    check("resp_err", resp_err, eerr);
    for (int h = 0; h < hold; h++) begin
      // The other port's resp_ready must not release the response.
      resp_ready = (g == 1) ? {1'b0, 1'($urandom_range(0, 1))} : {1'($urandom_range(0, 1)), 1'b0};
      @(posedge clk); #1;
      check("hold_rvalid", resp_valid, oh);
      check("hold_f", resp_f, ef);
      check("hold_flags", {resp_z, resp_v, resp_n, resp_c}, efl);
      check("hold_ready", req_ready, 2'b00);
    end
    resp_ready = oh;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    check("done_rvalid", resp_valid, 2'b00);
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_fs = '0; req_sh = '0;
    resp_ready = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; op_fs[p] = 0; op_a[p] = 0; op_b[p] = 0; op_sh[p] = 0;
    end
    last_served = 1;
    #2;
    check("rst_ready", req_ready, 2'b00);
    check("rst_rvalid", resp_valid, 2'b00);
    check("rst_f", resp_f, 32'h0);
    check("rst_flags", {resp_z, resp_v, resp_n, resp_c, resp_err}, 5'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Tie after reset: port 0 SUB 5-5 first, then port 1 XOR.
    set_op(0, 5'h05, 32'd5, 32'd5, 5'd0);
    set_op(1, 5'h0C, 32'hFF, 32'h0F, 5'd0);
    serve(0);
    check("tie_first_grant", obs_grant, 2'b01);
    check("sub_f", obs_f, 32'h0);
    check("sub_z", obs_flags[3], 1'b1);
    check("sub_c", obs_flags[0], 1'b0);
    serve(0);
    check("tie_second_grant", obs_grant, 2'b10);
    check("xor_f", obs_f, 32'hF0);

    // Port 0 alone: ADD overflow.
    set_op(0, 5'h02, 32'h7FFF_FFFF, 32'h1, 5'd0);
    serve(0);
    check("add_f", obs_f, 32'h8000_0000);
    check("add_zvnc", obs_flags, 4'b0110);

    // Port 1 LSR held 5 cycles while port 0 also waits.
    set_op(1, 5'h11, 32'h3, 32'h0, 5'd1);
    set_op(0, 5'h00, 32'h1234_5678, 32'h0, 5'd0);
    serve(5);
    check("lsr_grant", obs_grant, 2'b10);
    check("lsr_f", obs_f, 32'h1);
    check("lsr_zvnc", obs_flags, 4'b0001);
    serve(0);
    check("mov_f", obs_f, 32'h1234_5678);

    // Illegal FS, then a legal op clears the error.
    set_op(0, 5'h1F, 32'hDEAD_BEEF, 32'h1, 5'd3);
    serve(1);
    check("ill_err", obs_err, 1'b1);
    check("ill_f", obs_f, 32'h0);
    check("ill_flags", obs_flags, 4'b0000);
    set_op(0, 5'h08, 32'hF0F0, 32'hFF00, 5'd0);
    serve(0);
    check("legal_err", obs_err, 1'b0);
    check("and_f", obs_f, 32'hF000);

    // Reset during EXEC.
    set_op(0, 5'h02, 32'd1, 32'd2, 5'd0);
    drive_reqs();
    #1;
    check("pre_rst_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    pend[0] = 0;
    set_op(1, 5'h00, 32'h55, 32'h0, 5'd0);
    drive_reqs();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 2'b00);
    check("mid_rst_rvalid", resp_valid, 2'b00);
    check("mid_rst_f", resp_f, 32'h0);
    check("mid_rst_flags", {resp_z, resp_v, resp_n, resp_c, resp_err}, 5'b0);
    @(posedge clk); #1;
    check("mid_rst_rvalid2", resp_valid, 2'b00);
    rst_n = 1'b1;
    last_served = 1;
    set_op(0, 5'h0A, 32'h0F00, 32'h00F0, 5'd0);
    serve(0);
    check("post_rst_grant", obs_grant, 2'b01);
    check("or_f", obs_f, 32'h0FF0);
    serve(0);
    check("post_rst_second", obs_grant, 2'b10);

    // Randomized traffic.
    for (int it = 0; it < 300; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          logic [4:0] fs;
          fs = ($urandom_range(0, 7) == 0) ? 5'($urandom) : legal_fs[$urandom_range(0, 8)];
          set_op(p, fs, rand_val(), rand_val(), 5'($urandom));
        end
      end
      serve($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
